// File: rtl/hazard_pkg.sv
// Shared types and constants for the forwarding / load-use control slice.
// Stage tags carry rd at MAX_AW bits so any REG_AW up to MAX_AW fits.
package hazard_pkg;

    localparam int unsigned MAX_AW = 8;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam logic [MAX_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              v;
        logic [MAX_AW-1:0] rd;
        logic              rw;
        logic              ld;
    } stageTag_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Combinational forwarding select for one source operand; EX beats MEM.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [MAX_AW-1:0] src,
    input  logic              useSrc,
    input  stageTag_t         exTag,
    input  stageTag_t         memTag,
    output logic [1:0]        fwdSel_c
);

    logic exMatch;
    logic memMatch;
    logic unusedLdBits;

    // Load flags only matter to the hazard detector, not to the select.
    assign unusedLdBits = exTag.ld ^ memTag.ld;

    always_comb begin
        exMatch  = 1'b0;
        memMatch = 1'b0;
        fwdSel_c = FWD_NONE;

        exMatch  = exTag.v && exTag.rw && (exTag.rd != REG_ZERO)
                   && (exTag.rd == src) && useSrc;
        memMatch = memTag.v && memTag.rw && (memTag.rd != REG_ZERO)
                   && (memTag.rd == src) && useSrc;

        if (exMatch) begin
            fwdSel_c = FWD_EXMEM;
        end else if (memMatch) begin
            fwdSel_c = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding select registers and load-use stall/bubble for the 5-stage pipe.
// Optional performance counters are built when HAZ_PERF_EN is defined.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
`ifdef HAZ_PERF_EN
    ,
    parameter int unsigned CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    input  logic              hold,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              stall,
    output logic              bubble
`ifdef HAZ_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_fwd_cnt,
    output logic [CNT_W-1:0]  perf_stall_cnt
`endif
);

    stageTag_t         exTag;
    stageTag_t         memTag;
    stageTag_t         exTagNext;
    logic [MAX_AW-1:0] rsWide;
    logic [MAX_AW-1:0] rtWide;
    logic [MAX_AW-1:0] rdWide;
    logic [1:0]        selA_c;
    logic [1:0]        selB_c;
    logic [1:0]        fwdANext;
    logic [1:0]        fwdBNext;
    logic              loadUse;

    // Register indices are widened to the tag width (REG_AW must not exceed MAX_AW).
    assign rsWide = MAX_AW'(id_rs);
    assign rtWide = MAX_AW'(id_rt);
    assign rdWide = MAX_AW'(id_rd);

    hazard_fwd_sel u_selRs (
        .src      (rsWide),
        .useSrc   (id_use_rs),
        .exTag    (exTag),
        .memTag   (memTag),
        .fwdSel_c (selA_c)
    );

    hazard_fwd_sel u_selRt (
        .src      (rtWide),
        .useSrc   (id_use_rt),
        .exTag    (exTag),
        .memTag   (memTag),
        .fwdSel_c (selB_c)
    );

    // Hazard detection and next-state for the EX tag and operand selects.
    always_comb begin
        loadUse   = 1'b0;
        stall     = 1'b0;
        bubble    = 1'b0;
        exTagNext = '0;
        fwdANext  = FWD_NONE;
        fwdBNext  = FWD_NONE;

        loadUse = id_valid && exTag.v && exTag.ld && (exTag.rd != REG_ZERO)
                  && ((id_use_rs && (rsWide == exTag.rd))
                   || (id_use_rt && (rtWide == exTag.rd)));

        // Qualified by rst_n so nothing leaks out while reset is asserted.
        stall  = rst_n && !hold && loadUse;
        bubble = rst_n && !hold && (loadUse || flush);

        if (id_valid && !bubble) begin
            exTagNext.v  = 1'b1;
            exTagNext.rd = rdWide;
            exTagNext.rw = id_regwrite;
            exTagNext.ld = id_memread;
        end

        if (!bubble) begin
            fwdANext = selA_c;
            fwdBNext = selB_c;
        end
    end

    // Tag pipeline and registered selects; hold freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exTag     <= '0;
            memTag    <= '0;
            forward_a <= FWD_NONE;
            forward_b <= FWD_NONE;
        end else if (!hold) begin
            memTag    <= exTag;
            exTag     <= exTagNext;
            forward_a <= fwdANext;
            forward_b <= fwdBNext;
        end
    end

`ifdef HAZ_PERF_EN
    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fwd_cnt   <= '0;
            perf_stall_cnt <= '0;
        end else if (!hold) begin
            if (((fwdANext != FWD_NONE) || (fwdBNext != FWD_NONE))
                && (perf_fwd_cnt != {CNT_W{1'b1}})) begin
                perf_fwd_cnt <= perf_fwd_cnt + CNT_W'(1);
            end
            if (stall && (perf_stall_cnt != {CNT_W{1'b1}})) begin
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
